// File: rtl/bsg_gateway_pwr_seq_pkg.sv
// Shared types for the gateway power-up / bring-up sequencer.
package bsg_gateway_pwr_seq_pkg;

    // State encodings are visible on state_o (LEDs/debug), so they are fixed.
    typedef enum logic [3:0] {
        e_idle    = 4'd0,
        e_io_up   = 4'd1,
        e_core_up = 4'd2,
        e_pll_up  = 4'd3,
        e_lock    = 4'd4,
        e_tag     = 4'd5,
        e_link    = 4'd6,
        e_run     = 4'd7,
        e_pll_dn  = 4'd8,
        e_core_dn = 4'd9,
        e_io_dn   = 4'd10,
        e_fault   = 4'd11
    } pwr_state_e;

    typedef enum logic [1:0] {
        e_err_none  = 2'd0,
        e_err_lock  = 2'd1,
        e_err_tag   = 2'd2,
        e_err_calib = 2'd3
    } pwr_err_e;

    // clog2 that never returns 0, so a counter is always at least one bit wide.
    function automatic int safe_clog2(input int val);
        return (val <= 1) ? 1 : $clog2(val);
    endfunction

endpackage

// File: rtl/bsg_gateway_pwr_seq_timer.sv
// Loadable down-counter shared by all timed sequencer states.
module bsg_gateway_pwr_seq_timer #(
    parameter int ctr_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic [ctr_width_p-1:0] load_val_i,
    output logic                   zero_o
);

    logic [ctr_width_p-1:0] ctr_r;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ctr_r <= '0;
        end else if (load_i) begin
            ctr_r <= load_val_i;
        end else if (ctr_r != '0) begin
            ctr_r <= ctr_r - 1'b1;
        end
    end

    assign zero_o = (ctr_r == '0);

endmodule

// File: rtl/bsg_gateway_pwr_seq.sv
// Gateway-side power-up / bring-up sequencer.
//
// state   | meaning
// --------+-----------------------------------------------
// idle    | everything off, waiting for start_i
// io_up   | IO rail on, settling
// core_up | core rail on, settling
// pll_up  | PLL rail on, settling
// lock    | waiting for clock-generator lock
// tag     | tag reset released, waiting for tag done
// link    | link reset released, waiting for calibration
// run     | sequence complete, link usable
// pll_dn  | PLL rail off, settling
// core_dn | core rail off, settling
// io_dn   | IO rail off, settling
// fault   | all off, sticky error shown until start_i drops
module bsg_gateway_pwr_seq
    import bsg_gateway_pwr_seq_pkg::*;
#(
    parameter int rail_delay_p = 1024,
    parameter int timeout_p    = 65536,
    parameter int ctr_width_p  = safe_clog2((rail_delay_p > timeout_p) ? rail_delay_p : timeout_p)
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       locked_i,
    input  logic       tag_done_i,
    input  logic       calib_done_i,
    output logic       io_en_o,
    output logic       core_en_o,
    output logic       pll_en_o,
    output logic       tag_reset_o,
    output logic       link_reset_o,
    output logic       ready_o,
    output logic       error_o,
    output logic [1:0] err_code_o,
    output logic [3:0] state_o
);

    localparam logic [ctr_width_p-1:0] rail_load_lp    = ctr_width_p'(rail_delay_p - 1);
    localparam logic [ctr_width_p-1:0] timeout_load_lp = ctr_width_p'(timeout_p - 1);

    pwr_state_e             state_r, state_n;
    pwr_err_e               err_r, err_n;
    logic                   ctr_load;
    logic [ctr_width_p-1:0] ctr_load_val;
    logic                   ctr_zero;

    bsg_gateway_pwr_seq_timer #(
        .ctr_width_p(ctr_width_p)
    ) timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (ctr_load),
        .load_val_i(ctr_load_val),
        .zero_o    (ctr_zero)
    );

    // State and sticky error registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            err_r   <= e_err_none;
        end else begin
            state_r <= state_n;
            err_r   <= err_n;
        end
    end

    // Next state; start_i low beats any advance, and a late condition beats the timeout.
    always_comb begin
        state_n = state_r;
        err_n   = err_r;
        case (state_r)
            e_idle:    if (start_i) state_n = e_io_up;
            e_io_up:   if (!start_i) state_n = e_io_dn;
                       else if (ctr_zero) state_n = e_core_up;
            e_core_up: if (!start_i) state_n = e_core_dn;
                       else if (ctr_zero) state_n = e_pll_up;
            e_pll_up:  if (!start_i) state_n = e_pll_dn;
                       else if (ctr_zero) state_n = e_lock;
            e_lock: begin
                if (!start_i) state_n = e_pll_dn;
                else if (locked_i) state_n = e_tag;
                else if (ctr_zero) begin
                    state_n = e_pll_dn;
                    err_n   = e_err_lock;
                end
            end
            e_tag: begin
                if (!start_i) state_n = e_pll_dn;
                else if (tag_done_i) state_n = e_link;
                else if (ctr_zero) begin
                    state_n = e_pll_dn;
                    err_n   = e_err_tag;
                end
            end
            e_link: begin
                if (!start_i) state_n = e_pll_dn;
                else if (calib_done_i) state_n = e_run;
                else if (ctr_zero) begin
                    state_n = e_pll_dn;
                    err_n   = e_err_calib;
                end
            end
            e_run: begin
                if (!start_i) state_n = e_pll_dn;
                else if (!locked_i) begin
                    state_n = e_pll_dn;
                    err_n   = e_err_lock;
                end
            end
            e_pll_dn:  if (ctr_zero) state_n = e_core_dn;
            e_core_dn: if (ctr_zero) state_n = e_io_dn;
            e_io_dn:   if (ctr_zero) state_n = (err_r != e_err_none) ? e_fault : e_idle;
            e_fault: begin
                if (!start_i) begin
                    state_n = e_idle;
                    err_n   = e_err_none;
                end
            end
            default:   state_n = e_idle;
        endcase
    end

    // Reload the shared timer on every state entry with the new state's duration.
    always_comb begin
        ctr_load = (state_n != state_r);
        case (state_n)
            e_io_up, e_core_up, e_pll_up,
            e_pll_dn, e_core_dn, e_io_dn: ctr_load_val = rail_load_lp;
            e_lock, e_tag, e_link:        ctr_load_val = timeout_load_lp;
            default:                      ctr_load_val = '0;
        endcase
    end

    // Moore output decode from the state and error registers.
    always_comb begin
        io_en_o      = (state_r >= e_io_up)   && (state_r <= e_core_dn);
        core_en_o    = (state_r >= e_core_up) && (state_r <= e_pll_dn);
        pll_en_o     = (state_r >= e_pll_up)  && (state_r <= e_run);
        tag_reset_o  = !(state_r inside {e_tag, e_link, e_run});
        link_reset_o = !(state_r inside {e_link, e_run});
        ready_o      = (state_r == e_run);
        error_o      = (state_r == e_fault);
        err_code_o   = err_r;
        state_o      = state_r;
    end

endmodule

// File: tb/tb_bsg_gateway_pwr_seq.sv
// Bench for the gateway power sequencer: per-cycle comparison against a
// behavioural model plus directed timing checks from the bring-up plan.
module tb_bsg_gateway_pwr_seq;

    localparam int RD = 4;
    localparam int TO = 16;
    localparam logic [12:0] RESET_VEC = 13'b000_11_00_00_0000;

    logic       clk_i = 1'b0;
    logic       reset_i, start_i, locked_i, tag_done_i, calib_done_i;
    logic       io_en_o, core_en_o, pll_en_o, tag_reset_o, link_reset_o;
    logic       ready_o, error_o;
    logic [1:0] err_code_o;
    logic [3:0] state_o;
    logic [12:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Model: current state number, cycles spent in it (1 on entry), sticky error.
    int         m_state;
    int         m_age;
    logic [1:0] m_err;

    bsg_gateway_pwr_seq #(.rail_delay_p(RD), .timeout_p(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .locked_i(locked_i),
        .tag_done_i(tag_done_i), .calib_done_i(calib_done_i),
        .io_en_o(io_en_o), .core_en_o(core_en_o), .pll_en_o(pll_en_o),
        .tag_reset_o(tag_reset_o), .link_reset_o(link_reset_o), .ready_o(ready_o),
        .error_o(error_o), .err_code_o(err_code_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    assign dut_vec = {io_en_o, core_en_o, pll_en_o, tag_reset_o, link_reset_o,
                      ready_o, error_o, err_code_o, state_o};

    function automatic logic [12:0] expected_vec();
        logic io, core, pll, tr, lr, rdy, er;
        io   = (m_state >= 1 && m_state <= 9);
        core = (m_state >= 2 && m_state <= 8);
        pll  = (m_state >= 3 && m_state <= 7);
        tr   = !(m_state >= 5 && m_state <= 7);
        lr   = !(m_state == 6 || m_state == 7);
        rdy  = (m_state == 7);
        er   = (m_state == 11);
        return {io, core, pll, tr, lr, rdy, er, m_err, 4'(m_state)};
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_age   = 0;
        m_err   = 2'd0;
    endtask

    // Rules: rail phases last RD cycles, waits last up to TO cycles,
    // start low aborts (no error), a wait satisfied on its last cycle succeeds.
    task automatic model_step();
        int         ns;
        logic [1:0] ne;
        ns = m_state;
        ne = m_err;
        case (m_state)
            0:  if (start_i) ns = 1;
            1:  if (!start_i) ns = 10; else if (m_age == RD) ns = 2;
            2:  if (!start_i) ns = 9;  else if (m_age == RD) ns = 3;
            3:  if (!start_i) ns = 8;  else if (m_age == RD) ns = 4;
            4:  if (!start_i) ns = 8;  else if (locked_i) ns = 5;
                else if (m_age == TO) begin ns = 8; ne = 2'd1; end
            5:  if (!start_i) ns = 8;  else if (tag_done_i) ns = 6;
                else if (m_age == TO) begin ns = 8; ne = 2'd2; end
            6:  if (!start_i) ns = 8;  else if (calib_done_i) ns = 7;
                else if (m_age == TO) begin ns = 8; ne = 2'd3; end
            7:  if (!start_i) ns = 8;  else if (!locked_i) begin ns = 8; ne = 2'd1; end
            8:  if (m_age == RD) ns = 9;
            9:  if (m_age == RD) ns = 10;
            10: if (m_age == RD) ns = (m_err != 2'd0) ? 11 : 0;
            11: if (!start_i) begin ns = 0; ne = 2'd0; end
            default: ns = 0;
        endcase
        m_age   = (ns != m_state) ? 1 : m_age + 1;
        m_state = ns;
        m_err   = ne;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk_i);
        if (reset_i) model_reset();
        else model_step();
        #1;
        check(tag, dut_vec, expected_vec());
    endtask

    initial begin
        logic seen_last;
        int   k;

        reset_i = 1'b1; start_i = 1'b0; locked_i = 1'b0;
        tag_done_i = 1'b0; calib_done_i = 1'b0;
        model_reset();
        #2;
        check("reset_value", dut_vec, RESET_VEC);
        cycle("reset_hold");
        cycle("reset_hold");
        reset_i = 1'b0;
        for (int c = 0; c < 3; c++) cycle("idle");

        // Normal bring-up, then lock lost in RUN.
        check("bringup_io_c0", io_en_o, 1'b0);
        for (int c = 0; c < 40; c++) begin
            start_i = 1'b1; locked_i = 1'b1;
            tag_done_i = (c >= 20); calib_done_i = (c >= 30);
            cycle("bringup");
            if (c + 1 == 1)  check("io_rise_c1", io_en_o, 1'b1);
            if (c + 1 == 4)  check("core_off_c4", core_en_o, 1'b0);
            if (c + 1 == 5)  check("core_rise_c5", core_en_o, 1'b1);
            if (c + 1 == 8)  check("pll_off_c8", pll_en_o, 1'b0);
            if (c + 1 == 9)  check("pll_rise_c9", pll_en_o, 1'b1);
            if (c + 1 == 13) check("tag_rst_c13", tag_reset_o, 1'b1);
            if (c + 1 == 14) check("tag_rst_c14", tag_reset_o, 1'b0);
            if (c + 1 == 30) check("ready_c30", ready_o, 1'b0);
            if (c + 1 == 31) check("ready_c31", ready_o, 1'b1);
        end
        locked_i = 1'b0;
        cycle("lock_lost");
        check("lock_lost_resets", {ready_o, tag_reset_o, link_reset_o}, 3'b011);
        for (int c = 0; c < 14; c++) cycle("lock_lost_down");
        check("lock_lost_fault", {error_o, err_code_o, io_en_o}, 4'b1010);
        start_i = 1'b0;
        cycle("lock_lost_clear");
        check("lock_lost_idle", {state_o, err_code_o}, 6'b0000_00);

        // Lock timeout.
        for (int c = 0; c < 45; c++) begin
            start_i = 1'b1; locked_i = 1'b0;
            cycle("lock_timeout");
        end
        check("lock_to_fault", {error_o, err_code_o, io_en_o, core_en_o, pll_en_o}, 6'b101_000);
        start_i = 1'b0;
        cycle("lock_to_clear");
        check("lock_to_idle", {state_o, err_code_o}, 6'b0000_00);

        // Calibration on LINK's last count cycle wins.
        locked_i = 1'b1; tag_done_i = 1'b1;
        for (int c = 0; c < 60; c++) begin
            start_i = 1'b1;
            calib_done_i = (m_state == 6 && m_age == TO);
            cycle("calib_edge");
        end
        check("calib_edge_run", {state_o, error_o}, 5'b0111_0);
        start_i = 1'b0; calib_done_i = 1'b0;
        for (int c = 0; c < 14; c++) cycle("calib_edge_down");

        // Calibration one cycle too late faults.
        seen_last = 1'b0;
        for (int c = 0; c < 60; c++) begin
            start_i = 1'b1;
            calib_done_i = seen_last;
            if (m_state == 6 && m_age == TO) seen_last = 1'b1;
            cycle("calib_late");
        end
        check("calib_late_fault", {error_o, err_code_o}, 3'b111);
        start_i = 1'b0; calib_done_i = 1'b0;
        cycle("calib_late_clear");

        // Stop during CORE_UP at a random point, including its last cycle.
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(1, RD);
            start_i = 1'b1;
            for (int c = 0; c < 25; c++) begin
                if (m_state == 2 && m_age == k) start_i = 1'b0;
                cycle("stop_core");
                if (m_state == 9) check("stop_core_dn_rails", {io_en_o, core_en_o}, 2'b10);
            end
            check("stop_core_idle", {state_o, error_o, err_code_o}, 7'b0000_0_00);
        end

        // Randomized inputs against the model.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) < 3) start_i = ~start_i;
            locked_i     = ($urandom_range(0, 99) < 96);
            tag_done_i   = ($urandom_range(0, 99) < 20);
            calib_done_i = ($urandom_range(0, 99) < 20);
            cycle("random");
        end

        // Async reset while running.
        start_i = 1'b0;
        for (int c = 0; c < 20; c++) cycle("pre_reset_down");
        start_i = 1'b1; locked_i = 1'b1; tag_done_i = 1'b1; calib_done_i = 1'b1;
        for (int c = 0; c < 20; c++) cycle("pre_reset_up");
        check("pre_reset_run", ready_o, 1'b1);
        #3;
        reset_i = 1'b1;
        #1;
        check("async_reset", dut_vec, RESET_VEC);
        model_reset();
        start_i = 1'b0;
        cycle("reset_in_hold");
        cycle("reset_in_hold");
        reset_i = 1'b0;
        for (int c = 0; c < 3; c++) cycle("post_reset_idle");
        start_i = 1'b1;
        cycle("post_reset_start");
        check("post_reset_io", io_en_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_gateway_pwr_seq.md
Name: bsg_gateway_pwr_seq

Overview:
Gateway-side power-up/bring-up sequencer for the ASIC board.
- Up sequence: IO rail, core rail, PLL rail, each separated by a fixed delay. Then waits for clock-generator lock, releases bsg_tag reset, waits for tag done, releases comm-link reset, waits for calibration.
- Down sequence: reverse order on stop or on fault; faults are reported as sticky codes.
- Sits between the board-control GPIO override logic and the rail-enable, tag-reset and comm-link-reset nets.

Parameters:
- rail_delay_p, 1024: cycles each rail-up/rail-down state lasts; must be ≥1.
- timeout_p, 65536: maximum cycles to wait for lock, tag done or calibration; must be ≥1.
- ctr_width_p, `BSG_SAFE_CLOG2(max(rail_delay_p,timeout_p)): shared down-counter width.

Ports:
- clk_i  in  1  sequencer clock (board-control clock domain).
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  level: 1 = bring up / stay up, 0 = shut down.
- locked_i  in  1  clock generator locked; already synchronous to clk_i.
- tag_done_i  in  1  bsg_tag programming complete.
- calib_done_i  in  1  comm-link core calibration done.
- io_en_o  out  1  ASIC IO rail enable.
- core_en_o  out  1  ASIC core rail enable.
- pll_en_o  out  1  ASIC PLL rail enable.
- tag_reset_o  out  1  reset to the tag master, active-high.
- link_reset_o  out  1  reset to the comm link, active-high.
- ready_o  out  1  sequence complete, link usable.
- error_o  out  1  in FAULT.
- err_code_o  out  2  0 none, 1 lock timeout/lock lost, 2 tag timeout, 3 calib timeout.
- state_o  out  4  current state encoding, for LEDs/debug.

Behaviour:
Clocking, reset and outputs
- Single clock. Async active-high reset forces state IDLE, counter 0, err code 0.
- Reset values: all *_en_o=0, tag_reset_o=1, link_reset_o=1, ready_o=0, error_o=0, err_code_o=0, state_o=0.
- All outputs are registered/Moore, decoded from the state register and the sticky err register.

State encoding
- IDLE=0, IO_UP=1, CORE_UP=2, PLL_UP=3, LOCK=4, TAG=5, LINK=6, RUN=7, PLL_DN=8, CORE_DN=9, IO_DN=10, FAULT=11.

Rail decode
- io_en_o=1 in states 1–9.
- core_en_o=1 in states 2–8.
- pll_en_o=1 in states 3–7.

Reset and status decode
- tag_reset_o=0 only in TAG, LINK, RUN.
- link_reset_o=0 only in LINK, RUN.
- ready_o=1 only in RUN.
- error_o=1 only in FAULT.

Counter
- Loaded on every state entry: rail_delay_p-1 for IO_UP, CORE_UP, PLL_UP and all *_DN states; timeout_p-1 for LOCK, TAG, LINK.
- Decrements each cycle while nonzero.

Transitions
- IDLE→IO_UP when start_i=1.
- Rail states (IO_UP, CORE_UP, PLL_UP) advance when counter==0, so each lasts exactly rail_delay_p cycles.
- LOCK→TAG on locked_i; TAG→LINK on tag_done_i; LINK→RUN on calib_done_i.
- In LOCK/TAG/LINK, if the condition is false and counter==0: set err (1/2/3), go to PLL_DN. A condition true in the same cycle as counter==0 wins; no fault.
- RUN: locked_i=0 → err=1, go to PLL_DN.
- start_i=0 while going up:
  - IO_UP→IO_DN, CORE_UP→CORE_DN.
  - PLL_UP, LOCK, TAG, LINK, RUN→PLL_DN.
  - start_i=0 takes priority over an advance in the same cycle; err is not set.
- PLL_DN→CORE_DN→IO_DN, each after rail_delay_p cycles. start_i is ignored during the down sequence.
- IO_DN exit: to FAULT if err≠0, else to IDLE.
- FAULT holds (err_code_o stable) until start_i=0, then goes to IDLE and clears err.
- IDLE with start_i held at 1 restarts immediately; no retry happens from FAULT without a start_i low pulse.
- Latency: start_i rise to io_en_o=1 is 1 cycle (registered state).

Decomposition:
- Package bsg_gateway_pwr_seq_pkg holds the state enum (4-bit) and err_code enum (2-bit).
- One natural sub-module: bsg_gateway_pwr_seq_timer.
  - Loadable down-counter with load_i, load_val_i, zero_o; width ctr_width_p.
- FSM and output decode stay in the top module.

Test Plan:
All scenarios use rail_delay_p=4, timeout_p=16.
1. Normal bring-up: start_i=1 at cycle 0; locked_i high; tag_done_i at cycle 20; calib_done_i at cycle 30 → io_en_o rises cycle 1, core_en_o cycle 5, pll_en_o cycle 9; tag_reset_o falls on TAG entry (cycle 14); ready_o=1 cycle 31.
2. Lock timeout: locked_i=0 throughout → LOCK lasts 16 cycles; then PLL_DN/CORE_DN/IO_DN 4 cycles each; then FAULT with err_code_o=1, all rails 0. Dropping start_i → IDLE with err_code_o=0.
3. Boundary: calib_done_i asserted exactly on LINK's last count cycle → RUN, no fault; asserted one cycle later → FAULT, err_code_o=3.
4. Stop mid-sequence: start_i=0 during CORE_UP → next state CORE_DN (core_en_o=0, io_en_o=1 for 4 cycles), then IO_DN, then IDLE; error_o stays 0.
5. Lock lost in RUN: locked_i 1→0 → ready_o=0, tag_reset_o=1 and link_reset_o=1 next cycle; down sequence; FAULT with err_code_o=1.
6. Async reset asserted in RUN, between clock edges → all outputs return to reset values immediately; after release, idle until start_i=1.
